duty_slew: RTL and testbench

DUTY_SLEW -- requirements
Module: duty_slew

---
 rtl/duty_slew_pkg.sv | 18 +
 rtl/duty_slew_if.sv | 15 +
 rtl/duty_slew_period_tick.sv | 27 ++
 rtl/duty_slew.sv | 108 ++++++++++
 tb/tb_duty_slew.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/duty_slew_pkg.sv
// rtl/duty_slew_pkg.sv - shared state type and default parameters for duty_slew
// FAULT state exists only when DUTY_SLEW_FAULT_EN is defined.
package duty_slew_pkg;

    localparam int DEFAULT_DATA_WIDTH = 10;
    localparam int DEFAULT_STEP_SIZE  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
`ifdef DUTY_SLEW_FAULT_EN
        ,
        ST_FAULT     = 2'd3
`endif
    } slew_state_e;

endpackage

// File: rtl/duty_slew_if.sv
// rtl/duty_slew_if.sv - target handshake interface for duty_slew
interface duty_slew_if
    import duty_slew_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH
) ();

    logic [DataWidth-1:0] target;
    logic                 targetValid;
    logic                 targetReady;

    modport master (output target, output targetValid, input targetReady);
    modport slave  (input target, input targetValid, output targetReady);

endinterface

// File: rtl/duty_slew_period_tick.sv
// rtl/duty_slew_period_tick.sv - free-running period counter with end-of-period pulse
module period_tick
    import duty_slew_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH
) (
    input  logic clk,
    input  logic rstN,
    output logic periodEnd
);

    logic [DataWidth-1:0] cnt_q;
    logic [DataWidth-1:0] cnt_d;

    assign cnt_d = cnt_q + DataWidth'(1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign periodEnd = (cnt_q == {DataWidth{1'b1}});

endmodule

// File: rtl/duty_slew.sv
// rtl/duty_slew.sv - slew-limited PWM threshold ramp (top)
// Optional FAULT input/state enabled by DUTY_SLEW_FAULT_EN.
module duty_slew
    import duty_slew_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int StepSize  = DEFAULT_STEP_SIZE
) (
    input  logic                 clk,
    input  logic                 rstN,
`ifdef DUTY_SLEW_FAULT_EN
    input  logic                 faultN,
`endif
    duty_slew_if.slave           tgt_if,
    output logic [DataWidth-1:0] threshold,
    output logic                 busy,
    output logic                 periodEnd
);

    localparam logic [DataWidth-1:0] MAX_VAL = '1;
    localparam logic [DataWidth:0]   STEP    = (DataWidth+1)'(StepSize);

    slew_state_e          state_q, state_d;
    logic [DataWidth-1:0] thr_q, thr_d;
    logic [DataWidth-1:0] tgt_q, tgt_d;
    logic [DataWidth:0]   diff;

    period_tick #(.DataWidth(DataWidth)) u_tick (
        .clk       (clk),
        .rstN      (rstN),
        .periodEnd (periodEnd)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            thr_q   <= MAX_VAL;
            tgt_q   <= MAX_VAL;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            tgt_q   <= tgt_d;
        end
    end

    // Distance is taken one bit wider so the final partial step snaps exactly.
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        tgt_d   = tgt_q;
        diff    = '0;
        case (state_q)
            ST_IDLE: begin
                if (tgt_if.targetValid) begin
                    tgt_d = tgt_if.target;
                    if (tgt_if.target > thr_q) begin
                        state_d = ST_RAMP_UP;
                    end else if (tgt_if.target < thr_q) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
            end
            ST_RAMP_UP: begin
                diff = {1'b0, tgt_q} - {1'b0, thr_q};
                if (periodEnd) begin
                    if (diff <= STEP) begin
                        thr_d   = tgt_q;
                        state_d = ST_IDLE;
                    end else begin
                        thr_d = thr_q + STEP[DataWidth-1:0];
                    end
                end
            end
            ST_RAMP_DOWN: begin
                diff = {1'b0, thr_q} - {1'b0, tgt_q};
                if (periodEnd) begin
                    if (diff <= STEP) begin
                        thr_d   = tgt_q;
                        state_d = ST_IDLE;
                    end else begin
                        thr_d = thr_q - STEP[DataWidth-1:0];
                    end
                end
            end
`ifdef DUTY_SLEW_FAULT_EN
            ST_FAULT: begin
                if (faultN) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef DUTY_SLEW_FAULT_EN
        if (!faultN) begin
            state_d = ST_FAULT;
            thr_d   = MAX_VAL;
        end
`endif
    end

    assign tgt_if.targetReady = (state_q == ST_IDLE);
    assign busy               = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign threshold          = thr_q;

endmodule

// File: tb/tb_duty_slew.sv
// tb/tb_duty_slew.sv - directed self-checking bench for duty_slew (main 10-bit and short 6-bit instances)
module tb_duty_slew;

    localparam int MW   = 10;
    localparam int SW   = 6;
    localparam int STEP = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
`ifdef DUTY_SLEW_FAULT_EN
    logic faultN = 1'b1;
`endif

    always #5 clk = ~clk;

    duty_slew_if #(.DataWidth(MW)) m_if ();
    duty_slew_if #(.DataWidth(SW)) s_if ();

    logic [MW-1:0] m_thr;
    logic          m_busy;
    logic          m_pe;
    logic [SW-1:0] s_thr;
    logic          s_busy;
    logic          s_pe;

    int checks   = 0;
    int failures = 0;

    duty_slew #(.DataWidth(MW), .StepSize(STEP)) dut_m (
        .clk       (clk),
        .rstN      (rstN),
`ifdef DUTY_SLEW_FAULT_EN
        .faultN    (faultN),
`endif
        .tgt_if    (m_if.slave),
        .threshold (m_thr),
        .busy      (m_busy),
        .periodEnd (m_pe)
    );

    duty_slew #(.DataWidth(SW), .StepSize(STEP)) dut_s (
        .clk       (clk),
        .rstN      (rstN),
`ifdef DUTY_SLEW_FAULT_EN
        .faultN    (faultN),
`endif
        .tgt_if    (s_if.slave),
        .threshold (s_thr),
        .busy      (s_busy),
        .periodEnd (s_pe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the next periodEnd, i.e. just after the update edge.
    task automatic wait_m_pe(input string tag);
        int n = 0;
        while (m_pe !== 1'b1 && n < 2100) begin
            tick();
            n++;
        end
        if (m_pe !== 1'b1) check(tag, 32'(m_pe), 32'd1);
        tick();
    endtask

    task automatic wait_s_pe(input string tag);
        int n = 0;
        while (s_pe !== 1'b1 && n < 140) begin
            tick();
            n++;
        end
        if (s_pe !== 1'b1) check(tag, 32'(s_pe), 32'd1);
        tick();
    endtask

    task automatic send_m(input logic [MW-1:0] t);
        m_if.target      = t;
        m_if.targetValid = 1'b1;
        tick();
        m_if.targetValid = 1'b0;
    endtask

    task automatic send_s(input logic [SW-1:0] t);
        s_if.target      = t;
        s_if.targetValid = 1'b1;
        tick();
        s_if.targetValid = 1'b0;
    endtask

    initial begin
        m_if.target      = '0;
        m_if.targetValid = 1'b0;
        s_if.target      = '0;
        s_if.targetValid = 1'b0;

        #12;
        check("rst_thr",   32'(m_thr), 32'd1023);
        check("rst_busy",  32'(m_busy), 32'd0);
        check("rst_ready", 32'(m_if.targetReady), 32'd1);
        check("rst_pe",    32'(m_pe), 32'd0);
        check("rst_s_thr", 32'(s_thr), 32'd63);

        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 1022; i++) tick();
        check("pe_early", 32'(m_pe), 32'd0);
        tick();
        check("pe_first", 32'(m_pe), 32'd1);

        // Accept on the periodEnd cycle itself: the first step waits a full period.
        send_m(10'd1000);
        check("coinc_thr",   32'(m_thr), 32'd1023);
        check("coinc_busy",  32'(m_busy), 32'd1);
        check("coinc_ready", 32'(m_if.targetReady), 32'd0);
        wait_m_pe("wait_dn1");
        check("dn_1015", 32'(m_thr), 32'd1015);
        wait_m_pe("wait_dn2");
        check("dn_1007", 32'(m_thr), 32'd1007);
        wait_m_pe("wait_dn3");
        check("dn_1000", 32'(m_thr), 32'd1000);
        check("dn_idle_busy",  32'(m_busy), 32'd0);
        check("dn_idle_ready", 32'(m_if.targetReady), 32'd1);

        send_m(10'd1000);
        check("noop_busy",  32'(m_busy), 32'd0);
        check("noop_ready", 32'(m_if.targetReady), 32'd1);
        check("noop_thr",   32'(m_thr), 32'd1000);

        send_m(10'd900);
        check("mid_busy", 32'(m_busy), 32'd1);
        wait_m_pe("wait_mid");
        check("mid_992", 32'(m_thr), 32'd992);
        rstN = 1'b0;
        #1;
        check("mid_rst_thr",   32'(m_thr), 32'd1023);
        check("mid_rst_busy",  32'(m_busy), 32'd0);
        check("mid_rst_ready", 32'(m_if.targetReady), 32'd1);
        check("mid_rst_pe",    32'(m_pe), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        send_s(6'd0);
        check("full_busy", 32'(s_busy), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            wait_s_pe("wait_fdn");
            check("full_dn_step", 32'(s_thr), 32'(63 - STEP * k));
            if (k == 1) begin
                s_if.target      = 6'd30;
                s_if.targetValid = 1'b1;
            end
            check("block_ready", 32'(s_if.targetReady), 32'd0);
        end
        s_if.targetValid = 1'b0;
        wait_s_pe("wait_fdn_last");
        check("full_dn_snap", 32'(s_thr), 32'd0);
        check("full_dn_idle", 32'(s_busy), 32'd0);

        send_s(6'd63);
        for (int k = 1; k <= 7; k++) begin
            wait_s_pe("wait_fup");
            check("full_up_step", 32'(s_thr), 32'(STEP * k));
        end
        wait_s_pe("wait_fup_last");
        check("full_up_snap", 32'(s_thr), 32'd63);
        check("full_up_idle", 32'(s_busy), 32'd0);

`ifdef DUTY_SLEW_FAULT_EN
        send_m(10'd900);
        wait_m_pe("wait_flt");
        check("flt_pre", 32'(m_thr), 32'd1015);
        faultN = 1'b0;
        tick();
        check("flt_thr",   32'(m_thr), 32'd1023);
        check("flt_ready", 32'(m_if.targetReady), 32'd0);
        check("flt_busy",  32'(m_busy), 32'd0);
        tick();
        check("flt_hold", 32'(m_if.targetReady), 32'd0);
        faultN = 1'b1;
        tick();
        check("flt_exit_ready", 32'(m_if.targetReady), 32'd1);
        check("flt_exit_thr",   32'(m_thr), 32'd1023);
        check("flt_exit_busy",  32'(m_busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
